level_sequencer: RTL
====================

# level_sequencer

Game-flow controller sitting above the per-level obstacle generators. It owns the generators' `update` strobe and their active-high load signal `gen_rst`. It derives obstacle motion ticks from the VGA frame marker and sequences level load, play, pause, death, level advance, game-over and win. Level number and lives count feed the level-select mux and the HUD.

## Interface
Parameters:
- `NUM_LEVELS`, default 3: number of levels; last index is `NUM_LEVELS-1`.
- `FRAME_DIV`, default 1: frames per `update` pulse in PLAY (1..15).
- `DEATH_FRAMES`, default 60: frames spent in DYING (1..255).
- `START_LIVES`, default 3: lives loaded at new game (1..3).

Ports:
- `clk` input, 1: system (pixel) clock; single clock domain.
- `rst` input, 1: reset. Asynchronous assert, active-low.
- `vsync` input, 1: frame marker, synchronous to `clk`; rising edge = new frame.
- `start` input, 1: start/restart request; rising-edge detected.
- `pause` input, 1: pause toggle; rising-edge detected.
- `collision` input, 1: player hit an obstacle; level-sensitive, sampled in PLAY.
- `goal` input, 1: player reached the exit; level-sensitive, sampled in PLAY.
- `update` output, 1: one-`clk`-wide motion/load strobe to the generators.
- `gen_rst` output, 1: active-high load-start-positions to the generators.
- `level` output, 2: current level index.
- `lives` output, 2: remaining lives.
- `state` output, 3: current FSM state encoding, for debug and HUD.
- `game_over` output, 1: high while in OVER.
- `win` output, 1: high while in WIN.

## Operation
- States and encodings: IDLE=0, LOAD=1, PLAY=2, PAUSE=3, DYING=4, NEXT=5, OVER=6, WIN=7.
- IDLE: `gen_rst`=1. A `start` edge goes to LOAD.
- LOAD: lasts exactly 3 cycles.
  - L0: `gen_rst`=1, `update`=0.
  - L1: `gen_rst`=1, `update`=1.
  - L2: `gen_rst`=1, `update`=0.
  - Then PLAY. The frame counter is cleared on LOAD entry.
- PLAY:
  - `gen_rst`=0.
  - Each `vsync` rising edge increments a 4-bit frame counter.
  - When the counter equals `FRAME_DIV-1`, the counter is cleared and `update`=1 for one cycle.
- Exits from PLAY, in priority order:
  1. `collision` goes to DYING.
  2. `goal` goes to NEXT.
  3. A `pause` edge goes to PAUSE.
- PAUSE: no `update` pulses; the frame counter is held. A `pause` edge returns to PLAY with the counter unchanged. A `start` edge also returns to PLAY.
- DYING:
  - No `update` pulses. A death counter counts `vsync` edges.
  - At `DEATH_FRAMES`, if `lives`==1 then `lives` becomes 0 and the FSM goes to OVER.
  - Otherwise `lives` decrements and the FSM goes to LOAD with `level` unchanged.
- NEXT: one cycle.
  - If `level`==`NUM_LEVELS-1`, go to WIN.
  - Otherwise `level` increments and the FSM goes to LOAD.
- OVER/WIN: `gen_rst`=1; `game_over`/`win` held high. A `start` edge sets `level`=0 and `lives`=`START_LIVES`, then goes to LOAD.
- Edge detectors: one register each for `vsync`, `start` and `pause`. An edge is `in & ~in_q`.

## Timing
- Reset values:
  - `state`=IDLE, `level`=0, `lives`=`START_LIVES`.
  - `update`=0, `gen_rst`=1, `game_over`=0, `win`=0.
  - All counters and edge registers 0.
- `update` is registered. It goes high on the cycle after the clock edge at which the `vsync` edge is detected, and is never high on two consecutive cycles.
- A `vsync` edge on the same cycle as a PLAY exit condition: no `update` pulse.
- `gen_rst` is registered. It falls on the first PLAY cycle, i.e. at least one full `update` pulse is issued while it is high.
- Asserting `rst` mid-operation forces all outputs to reset values immediately, including `update` low, independent of `clk`.
- Inputs arriving in states that do not sample them are ignored, not queued.
- `level` never exceeds `NUM_LEVELS-1`. `lives` never wraps below 0.

## Configuration
- `LEVEL_SEQ_PAUSE_EN` defined: PAUSE state and `pause` edge logic are compiled in, as described above.
- Not defined: the `pause` input is ignored, PAUSE is unreachable, and the `pause` edge register is removed. All other behaviour is identical.

## Test plan
- Reset release, then `start` pulse: LOAD for 3 cycles with exactly one `update` pulse while `gen_rst`=1. Then `state`=2, `gen_rst`=0.
- `FRAME_DIV`=2, 6 `vsync` edges in PLAY: exactly 3 `update` pulses, each 1 cycle wide, one cycle after every second edge.
- `collision` and `goal` high on the same cycle, with `lives`=3: DYING. After 60 `vsync` edges, `lives`=2, `level` unchanged, LOAD re-entered.
- `lives`=1, then a collision: after `DEATH_FRAMES` edges, `state`=6, `game_over`=1, `lives`=0. Then `start`: `level`=0, `lives`=3, LOAD.
- `goal` on `level`=2 with `NUM_LEVELS`=3: NEXT, then WIN, `win`=1. With the macro defined, a `pause` edge in PLAY followed by 4 `vsync` edges gives 0 `update` pulses; a second `pause` edge resumes them.
- `rst` asserted during LOAD cycle L1: `update` drops to 0 asynchronously and `state`=IDLE. After release, the FSM stays in IDLE until a `start` edge.

Source files
------------

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM driving obstacle generators; define LEVEL_SEQ_PAUSE_EN to compile in PAUSE
module level_sequencer #(
    parameter int NUM_LEVELS   = 3,
    parameter int FRAME_DIV    = 1,
    parameter int DEATH_FRAMES = 60,
    parameter int START_LIVES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start,
    input  logic       pause,
    input  logic       collision,
    input  logic       goal,
    output logic       update,
    output logic       gen_rst,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over,
    output logic       win
);
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, PAUSE, DYING, NEXT, OVER, WIN} stateType;

    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_DIV - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [1:0] INIT_LIVES = 2'(START_LIVES);

    stateType curState, nextState;
    logic vsyncQ, startQ;
    logic vsyncEdge, startEdge, pauseEdge;
    logic [1:0] loadCnt;
    logic [3:0] frameCnt;
    logic [7:0] deathCnt;
    logic frameHit, deathHit, playExit;
    logic updateNext, genRstNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsyncQ <= 1'b0;
            startQ <= 1'b0;
        end else begin
            vsyncQ <= vsync;
            startQ <= start;
        end
    end

    assign vsyncEdge = vsync & ~vsyncQ;
    assign startEdge = start & ~startQ;

`ifdef LEVEL_SEQ_PAUSE_EN
    logic pauseQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pauseQ <= 1'b0;
        else      pauseQ <= pause;
    end

    assign pauseEdge = pause & ~pauseQ;
`else
    logic unusedPause;

    assign unusedPause = pause;
    assign pauseEdge   = 1'b0;
`endif

    assign frameHit = vsyncEdge && frameCnt == FRAME_LAST;
    assign deathHit = vsyncEdge && deathCnt == DEATH_LAST;
    assign playExit = collision | goal | pauseEdge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) curState <= IDLE;
        else      curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:      nextState = startEdge ? LOAD : IDLE;
            LOAD:      nextState = loadCnt == 2'd2 ? PLAY : LOAD;
            PLAY:      nextState = collision ? DYING : goal ? NEXT : pauseEdge ? PAUSE : PLAY;
            PAUSE:     nextState = (pauseEdge | startEdge) ? PLAY : PAUSE;
            DYING:     nextState = deathHit ? (lives <= 2'd1 ? OVER : LOAD) : DYING;
            NEXT:      nextState = level == LAST_LEVEL ? WIN : LOAD;
            OVER, WIN: nextState = startEdge ? LOAD : curState;
            default:   nextState = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered so update/gen_rst are glitch-free
    always_comb begin
        updateNext = (curState == LOAD && loadCnt == 2'd0) || (curState == PLAY && frameHit && !playExit);
        genRstNext = nextState == IDLE || nextState == LOAD || nextState == OVER || nextState == WIN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update   <= 1'b0;
            gen_rst  <= 1'b1;
            loadCnt  <= 2'd0;
            frameCnt <= 4'd0;
            deathCnt <= 8'd0;
            level    <= 2'd0;
            lives    <= INIT_LIVES;
        end else begin
            update   <= updateNext;
            gen_rst  <= genRstNext;
            loadCnt  <= curState == LOAD ? loadCnt + 2'd1 : 2'd0;
            frameCnt <= curState == LOAD ? 4'd0 :
                        (curState == PLAY && vsyncEdge && !playExit) ? (frameHit ? 4'd0 : frameCnt + 4'd1) :
                        frameCnt;
            deathCnt <= curState != DYING ? 8'd0 : vsyncEdge ? deathCnt + 8'd1 : deathCnt;
            if (curState == DYING && deathHit)
                lives <= lives <= 2'd1 ? 2'd0 : lives - 2'd1;
            if (curState == NEXT && level != LAST_LEVEL)
                level <= level + 2'd1;
            if ((curState == OVER || curState == WIN) && startEdge) begin
                level <= 2'd0;
                lives <= INIT_LIVES;
            end
        end
    end

    assign state     = curState;
    assign game_over = curState == OVER;
    assign win       = curState == WIN;
endmodule
